fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Upstream neighbour of the control unit: owns the program counter, fetches 9-bit instructions from a synchronous-read instruction ROM, and presents one instruction per execute slot.
- Consumes the control unit's branch decision and the LUT-resolved branch target to select the next PC.
- Detects HALT, and provides start/halted handshaking plus retired-instruction and cycle counters for benchmarking.
- Non-pipelined two-phase sequencer (FETCH, EXEC), so no flush logic is required.

Parameters:
PC_W, 10, program counter / instruction ROM address width
CNT_W, 16, width of the inst_count and cycle_count counters
RESET_PC, 0, PC loaded on reset and on every start

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins execution from RESET_PC
imem_addr  output  PC_W  instruction ROM address
imem_data  input  9  ROM read data, valid the cycle after imem_addr is presented
instruction  output  9  instruction to the control unit
inst_valid  output  1  high only in EXEC; gates register and memory writes downstream
ctrl_branch  input  1  from control unit: current instruction is a branch
take_branch  input  1  from control unit: branch condition true
branch_target  input  PC_W  absolute target from branch LUT
busy  output  1  high in FETCH or EXEC
halted  output  1  high in HALT state
pc  output  PC_W  current program counter
inst_count  output  CNT_W  instructions retired since last start
cycle_count  output  CNT_W  cycles spent in FETCH/EXEC since last start

Behaviour:
- Reset (async, reset_n=0): state=IDLE, pc=RESET_PC; imem_addr=RESET_PC; instruction, inst_valid, busy, halted, inst_count, cycle_count all 0. Takes effect immediately mid-operation; no instruction retires in the reset cycle.
- States: IDLE, FETCH, EXEC, HALT. FSM state, pc and counters are registered; imem_addr, instruction, inst_valid, busy and halted are combinational decodes of the state and registers.
- IDLE:
  - start=1: pc<=RESET_PC, inst_count<=0, cycle_count<=0, next state FETCH.
  - Otherwise hold.
- FETCH: imem_addr=pc; inst_valid=0; instruction=0; next state EXEC.
- EXEC:
  - instruction=imem_data (the word at pc); inst_valid=1.
  - HALT is decoded as opcode R_NEG with funct FUN_HALT, using the ControlUnit_def encodings. On HALT: next state HALT, pc unchanged, inst_count increments.
  - Otherwise pc <= (ctrl_branch & take_branch) ? branch_target : pc+1, inst_count increments, next state FETCH.
- Timing:
  - CPI=2; every instruction occupies exactly one FETCH and one EXEC cycle.
  - Branch latency: the target is fetched in the FETCH cycle immediately after the branch's EXEC.
- PC arithmetic: modulo 2^PC_W; pc+1 at all-ones wraps to 0 and execution continues.
- take_branch with ctrl_branch=0: ignored, pc+1.
- HALT:
  - halted=1, busy=0.
  - start=1 restarts exactly as from IDLE: counters clear, pc=RESET_PC, next state FETCH.
  - pc holds the address of the HALT instruction.
- start while busy (FETCH/EXEC): ignored.
- Counters:
  - cycle_count increments in every FETCH and EXEC cycle; it does not increment in IDLE or HALT.
  - Both counters saturate at all-ones; no wrap.
- imem_addr in IDLE/HALT/EXEC: holds pc, with no functional meaning.

Decomposition:
- Add FetchState enum (IDLE, FETCH, EXEC, HALT) to a new package FetchSequencer_def.
- Reuse Opcode, R_NEG and FUN_HALT from ControlUnit_def; no duplicated encodings.
- One natural sub-module: sat_counter (parameterised width, clear, enable, saturate), instantiated twice for inst_count and cycle_count.
- The instruction ROM stays outside this block.

Test Plan:
- Reset, no start for 10 cycles -> pc=0, halted=0, busy=0, inst_valid=0, counters=0.
- ROM[0..2]=three ADDs, ROM[3]=HALT; pulse start -> inst_valid high at cycles 2,4,6,8 with pc 0,1,2,3; halted=1 at cycle 9; inst_count=4; cycle_count=8.
- ROM[1]=branch; drive ctrl_branch=1, take_branch=1, branch_target=40 in its EXEC -> next FETCH imem_addr=40. Repeat with take_branch=0 -> imem_addr=2.
- PC_W=4, straight-line code at 15 -> after EXEC at pc=15, FETCH at pc=0. Branch to 15 also lands correctly.
- HALT reached, then start -> counters=0, pc=RESET_PC, FETCH next cycle. Start pulsed during EXEC -> no effect on pc or counters.
- Assert reset_n=0 mid-EXEC (between clock edges) -> outputs 0 and state IDLE immediately; inst_count not incremented. CNT_W=3 over a long run -> cycle_count holds at 7.

Source files
------------

// File: rtl/ControlUnit_def.sv
// Shared instruction encodings for the 9-bit ISA: opcode in [8:6], funct in [2:0].
package ControlUnit_def;

   typedef enum logic [2:0] {
      R_ADD = 3'd0,
      R_SUB = 3'd1,
      R_AND = 3'd2,
      R_OR  = 3'd3,
      R_LD  = 3'd4,
      R_ST  = 3'd5,
      R_BR  = 3'd6,
      R_NEG = 3'd7
   } Opcode;

   localparam logic [2:0] FUN_HALT = 3'b111;

endpackage

// File: rtl/FetchSequencer_def.sv
// Fetch sequencer state encoding and the HALT decode built on the control-unit encodings.
package FetchSequencer_def;

   import ControlUnit_def::*;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } FetchState;

   function automatic logic is_halt(input logic [8:0] instr);
      return (instr[8:6] == R_NEG) && (instr[2:0] == FUN_HALT);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Two-phase (FETCH/EXEC) program sequencer: owns the PC, fetches from a sync ROM,
// resolves branches, detects HALT and keeps benchmark counters.
module fetch_sequencer
   import FetchSequencer_def::*;
#(
   parameter int              PC_W     = 10,
   parameter int              CNT_W    = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   output logic [PC_W-1:0]  imem_addr,
   input  logic [8:0]       imem_data,
   output logic [8:0]       instruction,
   output logic             inst_valid,
   input  logic             ctrl_branch,
   input  logic             take_branch,
   input  logic [PC_W-1:0]  branch_target,
   output logic             busy,
   output logic             halted,
   output logic [PC_W-1:0]  pc,
   output logic [CNT_W-1:0] inst_count,
   output logic [CNT_W-1:0] cycle_count
);

   FetchState       state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            start_run;

   // start only has an effect from a resting state; mid-run pulses are dropped.
   assign start_run = start && ((state_q == IDLE) || (state_q == HALT));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         IDLE, HALT: begin
            if (start) begin
               state_d = FETCH;
               pc_d    = RESET_PC;
            end
         end
         FETCH: begin
            state_d = EXEC;
         end
         EXEC: begin
            // On HALT the PC is left pointing at the HALT word itself.
            if (is_halt(imem_data)) begin
               state_d = HALT;
            end else begin
               state_d = FETCH;
               pc_d    = (ctrl_branch && take_branch) ? branch_target : pc_q + PC_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   assign imem_addr   = pc_q;
   assign inst_valid  = (state_q == EXEC);
   assign instruction = inst_valid ? imem_data : 9'd0;
   assign busy        = (state_q == FETCH) || (state_q == EXEC);
   assign halted      = (state_q == HALT);
   assign pc          = pc_q;

   sat_counter #(.W(CNT_W)) u_inst_count (
      .clk   (clk),
      .rst_n (reset_n),
      .clr   (start_run),
      .en    (inst_valid),
      .count (inst_count)
   );

   sat_counter #(.W(CNT_W)) u_cycle_count (
      .clk   (clk),
      .rst_n (reset_n),
      .clr   (start_run),
      .en    (busy),
      .count (cycle_count)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a default-sized instance plus a PC_W=4/CNT_W=3 instance
// for wrap and saturation, both checked against a reference program walk.
module tb_fetch_sequencer;

   import ControlUnit_def::*;

   localparam logic [8:0] BR_I   = {3'(R_BR), 6'h2A};
   localparam logic [8:0] HALT_I = {3'(R_NEG), 3'b000, FUN_HALT};

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic s_start = 1'b0;

   always #5 clk = ~clk;

   // default instance
   logic [9:0]  imem_addr, branch_target, pc;
   logic [8:0]  imem_data, instruction;
   logic        inst_valid, ctrl_branch, take_branch, busy, halted;
   logic [15:0] inst_count, cycle_count;
   logic [8:0]  rom [0:1023];
   bit          br_en [0:1023];
   bit          br_take [0:1023];
   logic [9:0]  br_tgt [0:1023];

   // small instance
   logic [3:0]  s_imem_addr, s_branch_target, s_pc;
   logic [8:0]  s_imem_data, s_instruction;
   logic        s_inst_valid, s_ctrl_branch, s_take_branch, s_busy, s_halted;
   logic [2:0]  s_inst_count, s_cycle_count;
   logic [8:0]  s_rom [0:15];
   bit          s_br_en [0:15];
   bit          s_br_take [0:15];
   logic [3:0]  s_br_tgt [0:15];

   fetch_sequencer dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .instruction(instruction), .inst_valid(inst_valid),
      .ctrl_branch(ctrl_branch), .take_branch(take_branch), .branch_target(branch_target),
      .busy(busy), .halted(halted), .pc(pc),
      .inst_count(inst_count), .cycle_count(cycle_count)
   );

   fetch_sequencer #(.PC_W(4), .CNT_W(3), .RESET_PC(4'd12)) dut_s (
      .clk(clk), .reset_n(reset_n), .start(s_start),
      .imem_addr(s_imem_addr), .imem_data(s_imem_data),
      .instruction(s_instruction), .inst_valid(s_inst_valid),
      .ctrl_branch(s_ctrl_branch), .take_branch(s_take_branch), .branch_target(s_branch_target),
      .busy(s_busy), .halted(s_halted), .pc(s_pc),
      .inst_count(s_inst_count), .cycle_count(s_cycle_count)
   );

   // synchronous-read ROMs and a table-driven stand-in for the control unit
   always @(posedge clk) imem_data <= rom[imem_addr];
   always @(posedge clk) s_imem_data <= s_rom[s_imem_addr];
   assign ctrl_branch     = br_en[pc];
   assign take_branch     = br_take[pc];
   assign branch_target   = br_tgt[pc];
   assign s_ctrl_branch   = s_br_en[s_pc];
   assign s_take_branch   = s_br_take[s_pc];
   assign s_branch_target = s_br_tgt[s_pc];

   int n_checks = 0;
   int n_pass = 0;

   logic [34:0] exp_q[$];    // {inst index, pc, instruction}
   logic [20:0] s_exp_q[$];  // {inst index, pc, instruction}
   logic [34:0] m_e;
   logic [20:0] s_e;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [8:0] add_i(input logic [5:0] k);
      return {3'(R_ADD), k};
   endfunction

   function automatic bit is_halt_b(input logic [8:0] instr);
      return (instr[8:6] == R_NEG) && (instr[2:0] == FUN_HALT);
   endfunction

   function automatic int sat7(input int v);
      return (v > 7) ? 7 : v;
   endfunction

   // reference walk of the program from address 0
   task automatic build_main(output int n, output logic [9:0] last_pc);
      logic [9:0] p;
      p = 10'd0;
      n = 0;
      last_pc = 10'd0;
      exp_q.delete();
      for (int s = 0; s < 500; s++) begin
         exp_q.push_back({16'(n), p, rom[p]});
         n++;
         last_pc = p;
         if (is_halt_b(rom[p])) break;
         p = (br_en[p] && br_take[p]) ? br_tgt[p] : p + 10'd1;
      end
   endtask

   task automatic build_small(output int n, output logic [3:0] last_pc);
      logic [3:0] p;
      p = 4'd12;
      n = 0;
      last_pc = 4'd12;
      s_exp_q.delete();
      for (int s = 0; s < 100; s++) begin
         s_exp_q.push_back({8'(n), p, s_rom[p]});
         n++;
         last_pc = p;
         if (is_halt_b(s_rom[p])) break;
         p = (s_br_en[p] && s_br_take[p]) ? s_br_tgt[p] : p + 4'd1;
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (inst_valid) begin
            check("sb_avail", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               m_e = exp_q.pop_front();
               check("exec_pc", 32'(pc), 32'(m_e[18:9]));
               check("instr", 32'(instruction), 32'(m_e[8:0]));
               check("exec_icnt", 32'(inst_count), 32'(m_e[34:19]));
               check("exec_ccnt", 32'(cycle_count), 32'(m_e[34:19]) * 2 + 1);
            end
         end else if (busy && exp_q.size() > 0) begin
            check("fetch_addr", 32'(imem_addr), 32'(exp_q[0][18:9]));
            check("fetch_instr", 32'(instruction), 32'd0);
         end
         if (s_inst_valid) begin
            check("s_sb_avail", 32'(s_exp_q.size() > 0), 32'd1);
            if (s_exp_q.size() > 0) begin
               s_e = s_exp_q.pop_front();
               check("s_exec_pc", 32'(s_pc), 32'(s_e[12:9]));
               check("s_instr", 32'(s_instruction), 32'(s_e[8:0]));
               check("s_exec_icnt", 32'(s_inst_count), 32'(sat7(int'(s_e[20:13]))));
               check("s_exec_ccnt", 32'(s_cycle_count), 32'(sat7(2 * int'(s_e[20:13]) + 1)));
            end
         end else if (s_busy && s_exp_q.size() > 0) begin
            check("s_fetch_addr", 32'(s_imem_addr), 32'(s_exp_q[0][12:9]));
         end
      end
   end

   task automatic run_main(input bit glitch);
      int n;
      int k;
      logic [9:0] hpc;
      build_main(n, hpc);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("st_pc", 32'(pc), 32'd0);
      check("st_busy", 32'(busy), 32'd1);
      check("st_halted", 32'(halted), 32'd0);
      check("st_icnt", 32'(inst_count), 32'd0);
      check("st_ccnt", 32'(cycle_count), 32'd0);
      k = 0;
      while (!halted && k < 2000) begin
         @(posedge clk);
         #1 k++;
         start = glitch && (k == 1);
      end
      start = 1'b0;
      check("halt_cycle", 32'(k + 1), 32'(2 * n + 1));
      check("fin_icnt", 32'(inst_count), 32'(n));
      check("fin_ccnt", 32'(cycle_count), 32'(2 * n));
      check("fin_pc", 32'(pc), 32'(hpc));
      check("fin_busy", 32'(busy), 32'd0);
      check("fin_valid", 32'(inst_valid), 32'd0);
      check("sb_drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic run_small();
      int n;
      int k;
      logic [3:0] hpc;
      build_small(n, hpc);
      @(negedge clk) s_start = 1'b1;
      @(posedge clk);
      #1 s_start = 1'b0;
      check("s_st_pc", 32'(s_pc), 32'd12);
      k = 0;
      while (!s_halted && k < 500) begin
         @(posedge clk);
         #1 k++;
      end
      check("s_halt_cycle", 32'(k + 1), 32'(2 * n + 1));
      check("s_fin_icnt", 32'(s_inst_count), 32'(sat7(n)));
      check("s_fin_ccnt", 32'(s_cycle_count), 32'(sat7(2 * n)));
      check("s_fin_pc", 32'(s_pc), 32'(hpc));
      check("s_sb_drain", 32'(s_exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) begin
         rom[i] = add_i(6'(i));
         br_en[i] = 1'b0;
         br_take[i] = 1'b0;
         br_tgt[i] = 10'd0;
      end
      for (int i = 0; i < 16; i++) begin
         s_rom[i] = add_i(6'(i + 16));
         s_br_en[i] = 1'b0;
         s_br_take[i] = 1'b0;
         s_br_tgt[i] = 4'd0;
      end
      s_rom[2] = HALT_I;

      // reset then idle for 10 cycles
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'd0);
      check("rst_instr", 32'(instruction), 32'd0);
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_icnt", 32'(inst_count), 32'd0);
      check("rst_ccnt", 32'(cycle_count), 32'd0);
      check("s_rst_pc", 32'(s_pc), 32'd12);

      // three ADDs then HALT
      rom[3] = HALT_I;
      run_main(1'b0);

      // taken branch at pc 1 to 40, with a start pulse dropped during EXEC
      rom[1] = BR_I;
      br_en[1] = 1'b1;
      br_take[1] = 1'b1;
      br_tgt[1] = 10'd40;
      rom[41] = HALT_I;
      run_main(1'b1);

      // branch not taken, and take_branch without ctrl_branch ignored at pc 2
      br_take[1] = 1'b0;
      br_en[2] = 1'b0;
      br_take[2] = 1'b1;
      br_tgt[2] = 10'd100;
      rom[100] = HALT_I;
      run_main(1'b0);

      // small instance: branch to 15 then wrap; then straight-line wrap, counters saturate
      s_br_en[13] = 1'b1;
      s_br_take[13] = 1'b1;
      s_br_tgt[13] = 4'd15;
      run_small();
      s_br_en[13] = 1'b0;
      s_br_take[13] = 1'b0;
      run_small();

      // async reset landing mid-EXEC
      rom[3] = add_i(6'd3);
      rom[6] = HALT_I;
      br_en[1] = 1'b0;
      build_main_discard();
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_valid", 32'(inst_valid), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("mr_valid", 32'(inst_valid), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_instr", 32'(instruction), 32'd0);
      check("mr_pc", 32'(pc), 32'd0);
      check("mr_addr", 32'(imem_addr), 32'd0);
      check("mr_icnt", 32'(inst_count), 32'd0);
      check("mr_ccnt", 32'(cycle_count), 32'd0);
      @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_icnt", 32'(inst_count), 32'd0);
      check("post_rst_halted", 32'(halted), 32'd0);

      // recovers from IDLE with the same program
      run_main(1'b0);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   task automatic build_main_discard();
      int n;
      logic [9:0] hpc;
      build_main(n, hpc);
   endtask

endmodule
